// File: rtl/regfile_multiport.sv
// Parametrised PE register file: one synchronous write port and NUM_RD registered read
// ports, with optional write-to-read bypass and optional hardwired-zero register 0.
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] rd_next [NUM_RD];
  logic              wr_live;

  // A write to register 0 is dropped entirely when it is hardwired to zero, which also
  // keeps it from being forwarded to a same-cycle read.
  assign wr_live = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every entry is cleared on reset, so this array maps to flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_live) begin
      // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      // NOTE: each rd_next entry gets its default first, so no path can infer a latch.
      rd_next[p] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
      if ((BYPASS != 0) && wr_live && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W])) begin
        rd_next[p] = wr_data;
      end
      if ((ZERO_REG != 0) && (rd_addr[p*ADDR_W +: ADDR_W] == '0)) begin
        rd_next[p] = '0;
      end
    end
  end

  // Idle ports hold their last data; only the valid pulse drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      rd_valid <= rd_en;
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          rd_data[p*DATA_W +: DATA_W] <= rd_next[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: a default instance (2 ports, bypass, zero reg) and an alternate
// instance (3 ports, 16 entries, no bypass, ordinary r0), both checked against an array model.
module tb_regfile_multiport;

  logic clk;
  logic rst;

  logic [1:0]  a_rd_en;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_valid;
  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;

  logic [2:0]  b_rd_en;
  logic [11:0] b_rd_addr;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_valid;
  logic        b_wr_en;
  logic [3:0]  b_wr_addr;
  logic [31:0] b_wr_data;

  int total = 0;
  int bad   = 0;

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) u_a (
    .clk(clk), .rst(rst),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
  );

  regfile_multiport #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .BYPASS(0), .ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] ma [32];
  logic [31:0] mb [16];
  logic [31:0] ea [2];
  logic [31:0] eb [3];
  logic [1:0]  va;
  logic [2:0]  vb;
  bit          started = 0;

  // Value a read of register a returns, given its pre-write contents.
  function automatic logic [31:0] rd_val(input logic [31:0] old, input bit zero, input bit byp,
                                         input int a, input bit wen, input int wa,
                                         input logic [31:0] wd);
    if (zero && a == 0) return 32'h0;
    if (byp && wen && wa == a && !(zero && wa == 0)) return wd;
    return old;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (ma[i]) ma[i] = 32'h0;
      foreach (mb[i]) mb[i] = 32'h0;
      foreach (ea[i]) ea[i] = 32'h0;
      foreach (eb[i]) eb[i] = 32'h0;
      va = '0;
      vb = '0;
      started = 1;
    end else if (started) begin
      for (int p = 0; p < 2; p++)
        if (a_rd_en[p])
          ea[p] = rd_val(ma[a_rd_addr[p*5 +: 5]], 1, 1, int'(a_rd_addr[p*5 +: 5]),
                         a_wr_en, int'(a_wr_addr), a_wr_data);
      for (int p = 0; p < 3; p++)
        if (b_rd_en[p])
          eb[p] = rd_val(mb[b_rd_addr[p*4 +: 4]], 0, 0, int'(b_rd_addr[p*4 +: 4]),
                         b_wr_en, int'(b_wr_addr), b_wr_data);
      va = a_rd_en;
      vb = b_rd_en;
      if (a_wr_en && a_wr_addr != 5'd0) ma[a_wr_addr] = a_wr_data;
      if (b_wr_en) mb[b_wr_addr] = b_wr_data;
    end
    #1;
    if (started) begin
      for (int p = 0; p < 2; p++)
        check($sformatf("a_data%0d", p), a_rd_data[p*32 +: 32], ea[p]);
      check("a_valid", {30'h0, a_rd_valid}, {30'h0, va});
      for (int p = 0; p < 3; p++)
        check($sformatf("b_data%0d", p), b_rd_data[p*32 +: 32], eb[p]);
      check("b_valid", {29'h0, b_rd_valid}, {29'h0, vb});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    a_rd_en = '0; a_rd_addr = '0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
    b_rd_en = '0; b_rd_addr = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_both(input logic [4:0] addr, input logic [31:0] data);
    a_wr_en = 1'b1; a_wr_addr = addr;      a_wr_data = data;
    b_wr_en = 1'b1; b_wr_addr = addr[3:0]; b_wr_data = data;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;

    // Reset contents: every register reads 0 on all ports.
    for (int r = 1; r < 32; r++) begin
      logic [4:0] ra;
      ra = 5'(r);
      idle();
      a_rd_en = 2'b11; a_rd_addr = {ra, ra};
      b_rd_en = 3'b111; b_rd_addr = {ra[3:0], ra[3:0], ra[3:0]};
      tick();
      check("reset_a0", a_rd_data[31:0], 32'h0);
      check("reset_a1", a_rd_data[63:32], 32'h0);
      check("reset_av", {30'h0, a_rd_valid}, 32'h3);
    end

    // Write then read.
    idle(); wr_both(5'd5, 32'hDEADBEEF); tick();
    idle(); a_rd_en = 2'b01; a_rd_addr = {5'd0, 5'd5};
    b_rd_en = 3'b001; b_rd_addr = {4'd0, 4'd0, 4'd5}; tick();
    check("wr_rd_a", a_rd_data[31:0], 32'hDEADBEEF);
    check("wr_rd_b", b_rd_data[31:0], 32'hDEADBEEF);

    // Same-cycle write and read: bypass vs old value.
    idle(); wr_both(5'd7, 32'h11); tick();
    idle(); wr_both(5'd7, 32'h22);
    a_rd_en = 2'b10; a_rd_addr = {5'd7, 5'd0};
    b_rd_en = 3'b010; b_rd_addr = {4'd0, 4'd7, 4'd0}; tick();
    check("bypass_on", a_rd_data[63:32], 32'h22);
    check("bypass_off", b_rd_data[63:32], 32'h11);

    // Register 0 write, read same cycle and next cycle.
    idle(); wr_both(5'd0, 32'hFFFFFFFF);
    a_rd_en = 2'b01; b_rd_en = 3'b001; tick();
    check("x0_same_a", a_rd_data[31:0], 32'h0);
    check("x0_same_b", b_rd_data[31:0], 32'h0);
    idle(); a_rd_en = 2'b01; b_rd_en = 3'b001; tick();
    check("x0_next_a", a_rd_data[31:0], 32'h0);
    check("x0_next_b", b_rd_data[31:0], 32'hFFFFFFFF);

    // Hold on idle while the register is rewritten.
    idle(); wr_both(5'd3, 32'hA5); tick();
    idle(); a_rd_en = 2'b01; a_rd_addr = {5'd0, 5'd3}; tick();
    check("hold_first", a_rd_data[31:0], 32'hA5);
    for (int k = 0; k < 3; k++) begin
      idle(); wr_both(5'd3, $urandom); tick();
      check("hold_data", a_rd_data[31:0], 32'hA5);
      check("hold_valid", {31'h0, a_rd_valid[0]}, 32'h0);
    end

    // Highest address, back-to-back writes, last wins.
    idle(); wr_both(5'd31, 32'h1234); tick();
    idle(); wr_both(5'd31, 32'h5678); tick();
    idle(); a_rd_en = 2'b10; a_rd_addr = {5'd31, 5'd0}; tick();
    check("top_last_wins", a_rd_data[63:32], 32'h5678);

    // Reset mid-stream discards the pending read; first post-reset read is 0.
    idle(); a_rd_en = 2'b11; a_rd_addr = {5'd31, 5'd5}; b_rd_en = 3'b111; rst = 1'b1; tick();
    rst = 1'b0;
    check("rst_valid", {30'h0, a_rd_valid}, 32'h0);
    check("rst_data", a_rd_data[31:0], 32'h0);
    idle(); a_rd_en = 2'b01; a_rd_addr = {5'd0, 5'd5}; tick();
    check("post_rst_r5", a_rd_data[31:0], 32'h0);

    // Three ports on r15, r0, r15 of the 16-entry instance.
    idle(); wr_both(5'd15, 32'h3C); tick();
    idle(); b_rd_en = 3'b111; b_rd_addr = {4'd15, 4'd0, 4'd15}; tick();
    check("p3_port0", b_rd_data[31:0], 32'h3C);
    check("p3_port1", b_rd_data[63:32], 32'h0);
    check("p3_port2", b_rd_data[95:64], 32'h3C);

    // Randomised traffic; narrow address ranges half the time to force collisions.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] msk;
      msk = ($urandom_range(1, 0) == 1) ? 5'h03 : 5'h1F;
      rst        = ($urandom_range(63, 0) == 0);
      a_rd_en    = 2'($urandom);
      a_rd_addr  = {5'($urandom) & msk, 5'($urandom) & msk};
      a_wr_en    = 1'($urandom);
      a_wr_addr  = 5'($urandom) & msk;
      a_wr_data  = $urandom;
      b_rd_en    = 3'($urandom);
      b_rd_addr  = {4'($urandom) & msk[3:0], 4'($urandom) & msk[3:0], 4'($urandom) & msk[3:0]};
      b_wr_en    = 1'($urandom);
      b_wr_addr  = 4'($urandom) & msk[3:0];
      b_wr_data  = $urandom;
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
